mdio_reg_responder: RTL

- MAC-side register responder for the PHY register access path.
- Accepts single-cycle register-bus requests: control register at 14'h010, data register at 14'h014.
- Runs the requested IEEE 802.3 clause-22 MDIO frame on MDC/MDIO and answers each request with a one-cycle done pulse plus read data.
- Sits between the PHY register access initiator and the external PHY management pins.

---
 rtl/mdio_reg_responder_if.sv | 25 ++
 rtl/mdio_reg_responder.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/mdio_reg_responder_if.sv
// Register-bus and MDIO pin bundle for mdio_reg_responder.
// slave: the responder; master: the register initiator plus the PHY pin side.
interface mdio_reg_responder_if;
  logic        mac_request;
  logic [13:0] mac_addr;
  logic        mac_rdwn;
  logic [31:0] mac_wr_data;
  logic        mac_done;
  logic [31:0] mac_rd_data;
  logic        busy;
  logic        mdc;
  logic        mdio_out;
  logic        mdio_oe;
  logic        mdio_in;

  modport slave (
    input  mac_request, mac_addr, mac_rdwn, mac_wr_data, mdio_in,
    output mac_done, mac_rd_data, busy, mdc, mdio_out, mdio_oe
  );

  modport master (
    output mac_request, mac_addr, mac_rdwn, mac_wr_data, mdio_in,
    input  mac_done, mac_rd_data, busy, mdc, mdio_out, mdio_oe
  );
endinterface

// File: rtl/mdio_reg_responder.sv
// Register-bus responder that runs clause-22 MDIO read/write frames on MDC/MDIO.
// Define MDIO_PREAMBLE_SUPPRESS_EN to drop the 32-bit preamble (frame starts at ST).
module mdio_reg_responder #(
  parameter logic [4:0] PHY_ADDR = 5'd0,
  parameter int         MDC_DIV  = 20
) (
  input  logic               clk,
  input  logic               rst,
  mdio_reg_responder_if.slave bus
);
  localparam logic [13:0] CTRL_ADDR = 14'h010;
  localparam logic [13:0] DATA_ADDR = 14'h014;
  localparam logic [5:0]  CMD_RD    = 6'hD;
  localparam logic [5:0]  CMD_WR    = 6'hF;
  localparam int          DIV_W     = $clog2(MDC_DIV);
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  localparam logic [5:0]  START_BIT = 6'd32;
`else
  localparam logic [5:0]  START_BIT = 6'd0;
`endif

  typedef enum logic [1:0] {IDLE, REG_ACK, FRAME, FINISH} state_t;

  state_t             state, state_nxt;
  logic [15:0]        data_wr, data_rd;
  logic [10:0]        ctrl;
  logic [13:0]        req_addr;
  logic               req_rdwn;
  logic               frame_rd;
  logic [5:0]         bit_idx;
  logic               half;
  logic [DIV_W-1:0]   div_cnt;
  logic               done, busy, mdc, mdio_out, mdio_oe;
  logic [31:0]        rd_data;
  logic               start_frame, div_last, frame_end;
  logic               unused_wr_hi;

  // Line value for frame bit idx; read frames leave the line at 1 once released.
  function automatic logic frame_bit(input logic [5:0] idx, input logic rd,
                                     input logic [4:0] ra, input logic [15:0] wd);
    logic b;
    b = 1'b1;
    if (idx == 6'd32)                     b = 1'b0;
    else if (idx == 6'd34)                b = rd;
    else if (idx == 6'd35)                b = ~rd;
    else if (idx >= 6'd36 && idx <= 6'd40) b = PHY_ADDR[3'(6'd40 - idx)];
    else if (idx >= 6'd41 && idx <= 6'd45) b = ra[3'(6'd45 - idx)];
    else if (idx == 6'd47)                b = rd;
    else if (idx >= 6'd48)                b = rd | wd[4'(6'd63 - idx)];
    return b;
  endfunction

  function automatic logic frame_oe(input logic [5:0] idx, input logic rd);
    return ~rd | (idx <= 6'd45);
  endfunction

  assign start_frame = bus.mac_request && (bus.mac_addr == CTRL_ADDR) && !bus.mac_rdwn &&
                       ((bus.mac_wr_data[5:0] == CMD_RD) || (bus.mac_wr_data[5:0] == CMD_WR));
  assign div_last    = (div_cnt == DIV_W'(MDC_DIV - 1));
  assign frame_end   = div_last && half && (bit_idx == 6'd63);
  assign unused_wr_hi = ^bus.mac_wr_data[31:16];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.mac_request) state_nxt = start_frame ? FRAME : REG_ACK;
      REG_ACK: state_nxt = IDLE;
      FRAME:   if (frame_end) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture: only meaningful while a request is in flight, so no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.mac_request) begin
      req_addr <= bus.mac_addr;
      req_rdwn <= bus.mac_rdwn;
      frame_rd <= (bus.mac_wr_data[5:0] == CMD_RD);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done     <= 1'b0;
      rd_data  <= '0;
      busy     <= 1'b0;
      mdc      <= 1'b0;
      mdio_out <= 1'b1;
      mdio_oe  <= 1'b0;
      data_wr  <= '0;
      data_rd  <= '0;
      ctrl     <= '0;
      bit_idx  <= '0;
      half     <= 1'b0;
      div_cnt  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (bus.mac_request) begin
          busy <= 1'b1;
          if (!bus.mac_rdwn && bus.mac_addr == DATA_ADDR) data_wr <= bus.mac_wr_data[15:0];
          if (!bus.mac_rdwn && bus.mac_addr == CTRL_ADDR) ctrl <= bus.mac_wr_data[10:0];
          if (start_frame) begin
            bit_idx  <= START_BIT;
            half     <= 1'b0;
            div_cnt  <= '0;
            mdc      <= 1'b0;
            mdio_out <= frame_bit(START_BIT, bus.mac_wr_data[5:0] == CMD_RD,
                                  bus.mac_wr_data[10:6], data_wr);
            mdio_oe  <= 1'b1;
          end
        end
        REG_ACK: begin
          done <= 1'b1;
          busy <= 1'b0;
          if (req_rdwn && req_addr == DATA_ADDR)      rd_data <= {16'h0, data_rd};
          else if (req_rdwn && req_addr == CTRL_ADDR) rd_data <= {busy, 20'h0, ctrl};
          else                                        rd_data <= '0;
        end
        FRAME: begin
          if (!div_last) begin
            div_cnt <= div_cnt + 1'b1;
          end else if (!half) begin
            div_cnt <= '0;
            half    <= 1'b1;
            mdc     <= 1'b1;
            if (frame_rd && bit_idx >= 6'd48) data_rd <= {data_rd[14:0], bus.mdio_in};
          end else begin
            div_cnt <= '0;
            half    <= 1'b0;
            mdc     <= 1'b0;
            if (bit_idx == 6'd63) begin
              // Frame complete: release the line and answer the command write.
              mdio_oe  <= 1'b0;
              mdio_out <= 1'b1;
              done     <= 1'b1;
              busy     <= 1'b0;
              rd_data  <= frame_rd ? {16'h0, data_rd} : 32'h0;
            end else begin
              bit_idx  <= bit_idx + 6'd1;
              mdio_out <= frame_bit(bit_idx + 6'd1, frame_rd, ctrl[10:6], data_wr);
              mdio_oe  <= frame_oe(bit_idx + 6'd1, frame_rd);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mac_done    = done;
  assign bus.mac_rd_data = rd_data;
  assign bus.busy        = busy;
  assign bus.mdc         = mdc;
  assign bus.mdio_out    = mdio_out;
  assign bus.mdio_oe     = mdio_oe;
endmodule
